scan_inject_ctrl: RTL

SCAN_INJECT_CTRL -- requirements
Module: scan_inject_ctrl

---
 rtl/scan_inject_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/scan_inject_ctrl.sv
// Scan fault-injection controller; optional parity bit under SCAN_INJECT_PARITY_EN.
// Latency: first serial bit two cycles after setup; reads registered (1 cycle).
// Backpressure: full FIFO drops pushes; empty FIFO stalls shifting and flags underrun.
module scan_inject_ctrl #(
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int NCH        = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_CLK_SYS,
    input  logic              i_RST_SYS,
    input  logic [31:0]       i_ADDR,
    input  logic              i_WREn,
    input  logic              i_RDEn,
    input  logic [DATA_W-1:0] i_WRDATA,
    output logic [DATA_W-1:0] o_RDATA,
    output logic [NCH-1:0]    o_SERIAL_OUT,
    output logic [NCH-1:0]    o_EN_SR,
    output logic [NCH-1:0]    o_TFEn,
    output logic              o_RST
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_W);
`ifdef SCAN_INJECT_PARITY_EN
    localparam int CTRL_BITS = 3;
`else
    localparam int CTRL_BITS = 2;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CTRL, WAIT_START, FIRE} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       fifo_cnt;
    logic              fifo_full, fifo_empty, push_ok, pop;

    logic [3:0]        chsel, act_ch;
    logic [1:0]        ctrl_code, ctrl_idx;
    logic [LEN_W-1:0]  bits_rem;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] sr;
    logic              word_vld, underrun, rst_pulse;
    logic              ser_bit, en_bit, tf_bit, ctrl_bit;
    logic              wr_data, wr_ctrl, wr_chsel, abort, setup_req, start_req;
    logic [31:0]       status;
    logic              unused_addr;
`ifdef SCAN_INJECT_PARITY_EN
    logic              par_acc;
`endif

    assign unused_addr = ^i_ADDR[31:2];

    assign wr_data   = i_WREn && (i_ADDR[1:0] == 2'd0);
    assign wr_ctrl   = i_WREn && (i_ADDR[1:0] == 2'd1);
    assign wr_chsel  = i_WREn && (i_ADDR[1:0] == 2'd2);
    assign abort     = i_WREn && (i_ADDR[1:0] == 2'd3) && i_WRDATA[0];
    assign setup_req = wr_ctrl && i_WRDATA[2];
    assign start_req = wr_ctrl && i_WRDATA[3] && !i_WRDATA[2];

    assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign push_ok    = wr_data && (!fifo_full || pop);

    always_comb begin
        ctrl_bit = 1'b0;
        case (ctrl_idx)
            2'd0:    ctrl_bit = ctrl_code[0];
            2'd1:    ctrl_bit = ctrl_code[1];
`ifdef SCAN_INJECT_PARITY_EN
            2'd2:    ctrl_bit = ~(par_acc ^ ctrl_code[0] ^ ctrl_code[1]);
`endif
            default: ctrl_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        ser_bit   = 1'b0;
        en_bit    = 1'b0;
        tf_bit    = 1'b0;
        case (state)
            IDLE: if (setup_req) state_nxt = LOAD;
            LOAD: begin
                if (bits_rem == '0) begin
                    state_nxt = CTRL;
                end else if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (word_vld) begin
                    en_bit  = 1'b1;
                    ser_bit = sr[0];
                    if (bits_rem == LEN_W'(1))
                        state_nxt = CTRL;
                    else if (bit_idx == BW'(DATA_W-1) && !fifo_empty)
                        pop = 1'b1;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            CTRL: begin
                en_bit  = 1'b1;
                ser_bit = ctrl_bit;
                if (ctrl_idx == 2'(CTRL_BITS-1)) state_nxt = WAIT_START;
            end
            WAIT_START: if (start_req) state_nxt = FIRE;
            FIRE: begin
                tf_bit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge i_CLK_SYS) begin
        if (push_ok) fifo_mem[wr_ptr] <= i_WRDATA;
    end

    always_ff @(posedge i_CLK_SYS or posedge i_RST_SYS) begin
        if (i_RST_SYS) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            chsel     <= '0;
            act_ch    <= '0;
            ctrl_code <= '0;
            ctrl_idx  <= '0;
            bits_rem  <= '0;
            bit_idx   <= '0;
            sr        <= '0;
            word_vld  <= 1'b0;
            underrun  <= 1'b0;
            rst_pulse <= 1'b0;
`ifdef SCAN_INJECT_PARITY_EN
            par_acc   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            rst_pulse <= abort;
            if (wr_chsel) chsel <= i_WRDATA[3:0];
            if (abort) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
                underrun <= 1'b0;
                bits_rem <= '0;
                word_vld <= 1'b0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PW'(1);
                if (pop)     rd_ptr <= rd_ptr + PW'(1);
                if (push_ok && !pop)      fifo_cnt <= fifo_cnt + (PW+1)'(1);
                else if (pop && !push_ok) fifo_cnt <= fifo_cnt - (PW+1)'(1);
                if (pop) begin
                    sr       <= fifo_mem[rd_ptr];
                    bit_idx  <= '0;
                    word_vld <= 1'b1;
                end
                case (state)
                    IDLE: if (setup_req) begin
                        bits_rem  <= i_WRDATA[LEN_W+3:4];
                        ctrl_code <= i_WRDATA[1:0];
                        act_ch    <= chsel;
                        underrun  <= 1'b0;
                        ctrl_idx  <= '0;
                        word_vld  <= 1'b0;
`ifdef SCAN_INJECT_PARITY_EN
                        par_acc   <= 1'b0;
`endif
                    end
                    LOAD: if (bits_rem != '0 && fifo_empty) underrun <= 1'b1;
                    SHIFT: begin
                        if (word_vld) begin
                            bits_rem <= bits_rem - LEN_W'(1);
`ifdef SCAN_INJECT_PARITY_EN
                            par_acc  <= par_acc ^ sr[0];
`endif
                            if (bit_idx != BW'(DATA_W-1)) begin
                                sr      <= sr >> 1;
                                bit_idx <= bit_idx + BW'(1);
                            end else if (!pop && bits_rem != LEN_W'(1)) begin
                                word_vld <= 1'b0;
                                underrun <= 1'b1;
                            end
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                    CTRL: ctrl_idx <= ctrl_idx + 2'd1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        status            = '0;
        status[31]        = (state != IDLE);
        status[30]        = underrun;
        status[29]        = fifo_full;
        status[28]        = fifo_empty;
        status[LEN_W+3:4] = bits_rem;
    end

    always_ff @(posedge i_CLK_SYS or posedge i_RST_SYS) begin
        if (i_RST_SYS)
            o_RDATA <= '0;
        else if (i_RDEn)
            o_RDATA <= (i_ADDR[1:0] == 2'd1) ? DATA_W'(status) : DATA_W'({28'b0, chsel});
    end

    always_comb begin
        o_SERIAL_OUT = '0;
        o_EN_SR      = '0;
        o_TFEn       = '0;
        for (int i = 0; i < NCH; i++) begin
            if (act_ch == 4'(i)) begin
                o_SERIAL_OUT[i] = ser_bit;
                o_EN_SR[i]      = en_bit;
                o_TFEn[i]       = tf_bit;
            end
        end
    end

    assign o_RST = i_RST_SYS | rst_pulse;

endmodule
